// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: ResultSrc encodings and the memory-stage FSM states.
package riscv_pipe_pkg;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/c_IM_IW.sv
// M-to-W pipeline register, clocked on the falling edge. A bubble clears the
// write controls and holds the data fields.
module c_IM_IW
   import riscv_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        bubble,
   input  logic        RegWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [31:0] ALUResultM,
   input  logic [4:0]  RdM,
   input  logic [31:0] dmem_rdata,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [4:0]  RdW
);

   logic        reg_write_d, reg_write_q;
   logic [1:0]  result_src_d, result_src_q;
   logic [31:0] alu_result_d, alu_result_q;
   logic [31:0] read_data_d, read_data_q;
   logic [4:0]  rd_d, rd_q;

   always_comb begin
      reg_write_d  = 1'b0;
      result_src_d = RES_ALU;
      alu_result_d = alu_result_q;
      read_data_d  = read_data_q;
      rd_d         = rd_q;
      if (!bubble) begin
         reg_write_d  = RegWriteM;
         result_src_d = ResultSrcM;
         alu_result_d = ALUResultM;
         rd_d         = RdM;
         // Unstalled load implies the ack is present, so rdata is valid here.
         if (ResultSrcM == RES_LOAD) read_data_d = dmem_rdata;
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         reg_write_q  <= 1'b0;
         result_src_q <= RES_ALU;
         alu_result_q <= '0;
         read_data_q  <= '0;
         rd_q         <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         alu_result_q <= alu_result_d;
         read_data_q  <= read_data_d;
         rd_q         <= rd_d;
      end
   end

   assign RegWriteW  = reg_write_q;
   assign ResultSrcW = result_src_q;
   assign ALUResultW = alu_result_q;
   assign ReadDataW  = read_data_q;
   assign RdW        = rd_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues data-memory requests, stalls until ack and
// feeds the W register. MEM_TIMEOUT_EN adds a watchdog with sticky mem_err.
module mem_stage_ctrl
   import riscv_pipe_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  RdM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        StallM,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [4:0]  RdW,
   output logic        mem_err
);

   mem_state_e state_d, state_q;
   logic       mem_op;
   logic       req;
   logic       timeout;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_d, cnt_q;
   logic       err_d, err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      mem_op  = MemWriteM | (ResultSrcM == RES_LOAD);
      state_d = state_q;
      req     = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            req = mem_op;
            if (mem_op && !dmem_ack) state_d = WAIT;
         end
         WAIT: begin
            req = 1'b1;
            if (dmem_ack) state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               req     = 1'b0;
               timeout = 1'b1;
               state_d = IDLE;
            end
`endif
         end
      endcase
      // Reset must silence the bus combinationally, not just at the next edge.
      if (reset) req = 1'b0;
   end

`ifdef MEM_TIMEOUT_EN
   always_comb begin
      cnt_d = '0;
      if (state_q == WAIT && state_d == WAIT) cnt_d = cnt_q + 8'd1;
      err_d = err_q | timeout;
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign mem_err = err_q;
`else
   assign mem_err = 1'b0;
`endif

   always_ff @(negedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   assign dmem_req   = req;
   assign dmem_we    = req & MemWriteM;
   assign dmem_addr  = req ? ALUResultM : '0;
   assign dmem_wdata = req ? WriteDataM : '0;
   assign StallM     = req & ~dmem_ack;

   c_IM_IW u_im_iw (
      .clk        (clk),
      .reset      (reset),
      .bubble     (StallM | timeout),
      .RegWriteM  (RegWriteM),
      .ResultSrcM (ResultSrcM),
      .ALUResultM (ALUResultM),
      .RdM        (RdM),
      .dmem_rdata (dmem_rdata),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .RdW        (RdW)
   );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl; state changes on the falling edge, so
// inputs are driven and outputs sampled 1ns after each falling edge.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
   localparam int TO_CYC = 4;
`else
   localparam int TO_CYC = 255;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [31:0] ALUResultM, WriteDataM;
   logic [4:0]  RdM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        StallM, RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW, ReadDataW;
   logic [4:0]  RdW;
   logic        mem_err;

   int n_assert = 0;
   int n_fail   = 0;

   mem_stage_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .reset(reset),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
      .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic set_m(input logic rw, input logic mw, input logic [1:0] rs,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
      RegWriteM  = rw;
      MemWriteM  = mw;
      ResultSrcM = rs;
      ALUResultM = alu;
      WriteDataM = wd;
      RdM        = rd;
   endtask

   initial begin
      reset      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      set_m(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      #2 reset = 1'b1;
      #1;
      check("rst_req", dmem_req, 0);
      check("rst_stall", StallM, 0);
      check("rst_regwrite", RegWriteW, 0);
      check("rst_rdata", ReadDataW, 0);
      check("rst_rd", RdW, 0);
      check("rst_alu", ALUResultW, 0);
      check("rst_err", mem_err, 0);
      cyc();
      reset = 1'b0;

      // ALU op passes in one edge
      set_m(1'b1, 1'b0, 2'b00, 32'd7, 32'h0, 5'd5);
      #1;
      check("alu_req", dmem_req, 0);
      check("alu_stall", StallM, 0);
      check("alu_addr", dmem_addr, 0);
      cyc();
      check("alu_rdw", RdW, 5);
      check("alu_resw", ALUResultW, 7);
      check("alu_rw", RegWriteW, 1);

      // Load with ack already high: zero stall
      set_m(1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 5'd3);
      dmem_ack = 1'b1;
      dmem_rdata = 32'hDEADBEEF;
      #1;
      check("ld_req", dmem_req, 1);
      check("ld_addr", dmem_addr, 32'h100);
      check("ld_we", dmem_we, 0);
      check("ld_stall", StallM, 0);
      cyc();
      check("ld_rdata", ReadDataW, 32'hDEADBEEF);
      check("ld_rw", RegWriteW, 1);
      check("ld_src", ResultSrcW, 1);
      check("ld_rd", RdW, 3);

      // Store with 3 stall cycles
      set_m(1'b0, 1'b1, 2'b00, 32'h200, 32'h55, 5'd0);
      dmem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("st_stall", StallM, 1);
         check("st_we", dmem_we, 1);
         check("st_addr", dmem_addr, 32'h200);
         check("st_wdata", dmem_wdata, 32'h55);
         cyc();
         check("st_bubble_rw", RegWriteW, 0);
         check("st_bubble_src", ResultSrcW, 0);
         check("st_hold_alu", ALUResultW, 32'h100);
         check("st_hold_rd", RdW, 3);
      end
      dmem_ack = 1'b1;
      #1;
      check("st_done_stall", StallM, 0);
      check("st_done_req", dmem_req, 1);
      cyc();
      check("st_done_alu", ALUResultW, 32'h200);
      check("st_done_rd", RdW, 0);
      check("st_keep_rdata", ReadDataW, 32'hDEADBEEF);
      dmem_ack = 1'b0;

      // Back-to-back loads, one wait cycle each
      set_m(1'b1, 1'b0, 2'b00, 32'h11, 32'h0, 5'd9);
      cyc();
      check("pre_rw", RegWriteW, 1);
      set_m(1'b1, 1'b0, 2'b01, 32'h300, 32'h0, 5'd6);
      #1;
      check("lda_stall", StallM, 1);
      cyc();
      check("lda_bubble", RegWriteW, 0);
      check("lda_hold_rd", RdW, 9);
      dmem_ack = 1'b1;
      dmem_rdata = 32'hA5A50001;
      #1;
      check("lda_ack_stall", StallM, 0);
      cyc();
      check("lda_rdata", ReadDataW, 32'hA5A50001);
      check("lda_rd", RdW, 6);
      check("lda_rw", RegWriteW, 1);
      set_m(1'b1, 1'b0, 2'b01, 32'h304, 32'h0, 5'd7);
      dmem_ack = 1'b0;
      #1;
      check("ldb_req", dmem_req, 1);
      check("ldb_addr", dmem_addr, 32'h304);
      check("ldb_stall", StallM, 1);
      cyc();
      check("ldb_bubble", RegWriteW, 0);
      check("ldb_hold_rdata", ReadDataW, 32'hA5A50001);
      check("ldb_hold_alu", ALUResultW, 32'h300);
      dmem_ack = 1'b1;
      dmem_rdata = 32'hA5A50002;
      cyc();
      check("ldb_rdata", ReadDataW, 32'hA5A50002);
      check("ldb_rd", RdW, 7);
      check("ldb_rw", RegWriteW, 1);
      check("ldb_alu", ALUResultW, 32'h304);
      dmem_ack = 1'b0;

      // Reset in the second WAIT cycle, then a late ack
      set_m(1'b1, 1'b0, 2'b01, 32'h400, 32'h0, 5'd4);
      cyc();
      cyc();
      check("rw_stall", StallM, 1);
      check("rw_req", dmem_req, 1);
      reset = 1'b1;
      #1;
      check("rw_req_drop", dmem_req, 0);
      check("rw_stall_drop", StallM, 0);
      check("rw_rw", RegWriteW, 0);
      check("rw_rdata", ReadDataW, 0);
      check("rw_rd", RdW, 0);
      set_m(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      cyc();
      reset = 1'b0;
      dmem_ack = 1'b1;
      dmem_rdata = 32'hBAD0BAD0;
      #1;
      check("late_req", dmem_req, 0);
      check("late_stall", StallM, 0);
      cyc();
      check("late_rdata", ReadDataW, 0);
      check("late_rw", RegWriteW, 0);
      dmem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
      // No ack: watchdog releases on the 4th WAIT cycle
      set_m(1'b1, 1'b0, 2'b01, 32'h500, 32'h0, 5'd8);
      #1;
      check("to_issue_stall", StallM, 1);
      cyc();
      for (int i = 0; i < 3; i++) begin
         check("to_wait_stall", StallM, 1);
         check("to_wait_err", mem_err, 0);
         cyc();
      end
      check("to_rel_req", dmem_req, 0);
      check("to_rel_stall", StallM, 0);
      check("to_rel_err", mem_err, 0);
      cyc();
      check("to_err", mem_err, 1);
      check("to_bubble", RegWriteW, 0);
      check("to_keep_rdata", ReadDataW, 0);
      set_m(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      #1;
      check("to_idle_req", dmem_req, 0);
      cyc();
      check("to_err_sticky", mem_err, 1);
`else
      // Without the watchdog WAIT persists until ack
      set_m(1'b0, 1'b1, 2'b00, 32'h600, 32'h77, 5'd0);
      for (int i = 0; i < 6; i++) begin
         #1;
         check("nw_stall", StallM, 1);
         check("nw_err", mem_err, 0);
         cyc();
      end
      dmem_ack = 1'b1;
      #1;
      check("nw_done_stall", StallM, 0);
      cyc();
      check("nw_done_alu", ALUResultW, 32'h600);
      dmem_ack = 1'b0;
      set_m(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      #1;
      check("nw_idle_req", dmem_req, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, is the watchdog limit in cycles (used only with MEM_TIMEOUT_EN).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  pipeline clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-high reset.
- RegWriteM  in  1  M-stage register-write control.
- MemWriteM  in  1  M-stage store control.
- ResultSrcM  in  2  M-stage result select; 2'b01 = load.
- ALUResultM  in  32  data address or ALU result.
- WriteDataM  in  32  store data.
- RdM  in  5  destination register.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  data-memory write enable.
- dmem_addr  out  32  data-memory address.
- dmem_wdata  out  32  data-memory write data.
- dmem_ack  in  1  memory completion, sampled at the falling edge.
- dmem_rdata  in  32  load data, valid with dmem_ack.
- StallM  out  1  holds the F/D/E/M stages while a memory access is outstanding.
- RegWriteW  out  1  W-stage register-write control.
- ResultSrcW  out  2  W-stage result select.
- ALUResultW  out  32  W-stage ALU result.
- ReadDataW  out  32  W-stage load data.
- RdW  out  5  W-stage destination register.
- mem_err  out  1  sticky timeout error (MEM_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-003 mem_op SHALL be MemWriteM | (ResultSrcM == 2'b01).
REQ-004 The FSM SHALL have two states, IDLE and WAIT.
REQ-005 IDLE: dmem_req = mem_op, combinationally in the same cycle; if dmem_ack is also high, the op completes with zero stall cycles, otherwise the next state is WAIT.
REQ-006 WAIT: dmem_req is held at 1; on dmem_ack the next state is IDLE.
REQ-007 dmem_addr = ALUResultM, dmem_wdata = WriteDataM, dmem_we = MemWriteM whenever dmem_req = 1; all three are 0 when dmem_req = 0.
REQ-008 StallM = mem_op & ~dmem_ack (combinational).
REQ-009 The M-stage inputs SHALL remain stable while StallM = 1; the block does not re-latch them.
REQ-010 W register, when StallM = 0 at the edge: RegWriteW, ResultSrcW, ALUResultW and RdW load from the M-stage inputs; ReadDataW loads dmem_rdata on a load and is held otherwise.
REQ-011 W register, when StallM = 1 at the edge: insert a bubble (RegWriteW = 0, ResultSrcW = 0); the other W fields are held.
REQ-012 Back-to-back memory ops: completing an op in WAIT returns to IDLE, and the following op is issued in the next cycle with no idle gap.
REQ-013 A dmem_ack while dmem_req = 0 SHALL be ignored.
REQ-014 Non-memory instructions (mem_op = 0) SHALL pass to W in one cycle, with dmem_req = 0 and StallM = 0.

Reset
REQ-015 Asserting reset, at any time including during WAIT, SHALL immediately clear state to IDLE and drive dmem_req = 0, StallM = 0, and all W outputs, mem_err and the watchdog counter to 0.
REQ-016 A memory transaction in flight at reset is abandoned; a late dmem_ack after reset is ignored (REQ-013).

Configuration
REQ-017 Macro MEM_TIMEOUT_EN:
- Defined: an 8-bit counter increments each cycle in WAIT and clears on leaving WAIT.
- On reaching TIMEOUT_CYCLES with no ack: force IDLE, deassert dmem_req and StallM for one cycle, insert a W bubble, and set mem_err (cleared only by reset).
- Undefined: no counter; WAIT persists until dmem_ack; mem_err is tied to 0.

Structure
REQ-018 Shared package riscv_pipe_pkg SHALL hold the ResultSrc encodings (RES_ALU = 2'b00, RES_LOAD = 2'b01, RES_PC4 = 2'b10) and the IDLE/WAIT state enum.
REQ-019 The M-to-W register with stall-bubble behaviour SHALL be the sub-module c_IM_IW; the FSM, request logic and watchdog stay in mem_stage_ctrl.

Verification
REQ-020 Load: ResultSrcM = 01, ALUResultM = 0x100, dmem_ack held high -> dmem_req = 1 with address 0x100, StallM = 0, ReadDataW = dmem_rdata (0xDEADBEEF) one edge later.
REQ-021 Store with 3-cycle ack latency: MemWriteM = 1, WriteDataM = 0x55 -> StallM high for exactly 3 cycles, dmem_we/addr/wdata stable throughout, three RegWriteW = 0 bubbles.
REQ-022 ALU op (RegWriteM = 1, RdM = 5, ALUResultM = 7) -> RdW = 5 and ALUResultW = 7 after one edge, dmem_req = 0.
REQ-023 Reset asserted in cycle 2 of WAIT -> dmem_req and StallM drop immediately; a late ack produces no W update.
REQ-024 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, ack never arrives -> mem_err = 1 after 4 WAIT cycles, state returns to IDLE, a bubble is written.
REQ-025 Two consecutive loads, each acked after 1 wait cycle -> both ReadDataW values appear in order, with no lost or duplicated W writes.
